// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard for the D stage: tracks producer tags in the stages
// after Decode, picks the youngest matching producer per operand and raises stall when data is late.
module fwd_scoreboard #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned NUM_SRC = 2,
   parameter int unsigned DEPTH   = 3,
   parameter int unsigned TNEW_W  = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        d_valid,
   input  logic                        d_we,
   input  logic [ADDR_W-1:0]           d_dst,
   input  logic [TNEW_W-1:0]           d_tnew,
   input  logic [NUM_SRC*ADDR_W-1:0]   d_src_addr,
   input  logic [NUM_SRC*TNEW_W-1:0]   d_src_tuse,
   input  logic [NUM_SRC*DATA_W-1:0]   d_src_data,
   input  logic [DEPTH*DATA_W-1:0]     stage_data,
   input  logic                        flush,
   output logic                        stall,
   output logic [NUM_SRC*DATA_W-1:0]   src_fwd_data,
   output logic [DEPTH-1:0]            stage_we,
   output logic [31:0]                 stall_cnt
);

   localparam int unsigned CNT_W = 32;

   logic [DEPTH-1:0]             tag_we_q,   tag_we_d;
   logic [DEPTH-1:0][ADDR_W-1:0] tag_dst_q,  tag_dst_d;
   logic [DEPTH-1:0][TNEW_W-1:0] tag_tnew_q, tag_tnew_d;
   logic [CNT_W-1:0]             stall_cnt_q, stall_cnt_d;

   logic [NUM_SRC-1:0]           src_found;
   logic [NUM_SRC-1:0]           src_stall;
   logic [NUM_SRC*DATA_W-1:0]    fwd_data;
   logic                         stall_any;
   logic                         insert;

   // Per-operand scan: the first hit from index 0 upward is the youngest producer.
   always_comb begin
      src_found = '0;
      src_stall = '0;
      fwd_data  = d_src_data;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!src_found[k] && tag_we_q[i]
                && (d_src_addr[k*ADDR_W +: ADDR_W] != '0)
                && (tag_dst_q[i] == d_src_addr[k*ADDR_W +: ADDR_W])) begin
               src_found[k] = 1'b1;
               if (tag_tnew_q[i] == '0) begin
                  fwd_data[k*DATA_W +: DATA_W] = stage_data[i*DATA_W +: DATA_W];
               end else begin
                  src_stall[k] = (tag_tnew_q[i] > d_src_tuse[k*TNEW_W +: TNEW_W]);
               end
            end
         end
      end
   end

   assign stall_any    = (|src_stall) & ~reset;
   assign stall        = stall_any;
   assign src_fwd_data = reset ? d_src_data : fwd_data;
   assign stage_we     = tag_we_q;
   assign stall_cnt    = stall_cnt_q;

   assign insert = d_valid & d_we & (d_dst != '0) & ~stall_any & ~flush;

   // Index 0 takes the D instruction or a bubble; older entries shift and age every cycle.
   always_comb begin
      tag_we_d   = '0;
      tag_dst_d  = '0;
      tag_tnew_d = '0;
      tag_we_d[0]   = insert;
      tag_dst_d[0]  = insert ? d_dst  : '0;
      tag_tnew_d[0] = insert ? d_tnew : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         tag_we_d[i]   = tag_we_q[i-1];
         tag_dst_d[i]  = tag_dst_q[i-1];
         tag_tnew_d[i] = (tag_tnew_q[i-1] == '0) ? '0 : (tag_tnew_q[i-1] - TNEW_W'(1));
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_any && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_we_q    <= '0;
         tag_dst_q   <= '0;
         tag_tnew_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         tag_we_q    <= tag_we_d;
         tag_dst_q   <= tag_dst_d;
         tag_tnew_q  <= tag_tnew_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: expectations queued as stimulus is driven, popped on check.
module tb_fwd_scoreboard;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned NUM_SRC = 2;
   localparam int unsigned DEPTH   = 3;
   localparam int unsigned TNEW_W  = 2;

   localparam logic [31:0] SRC0 = 32'hA0A0_0000;
   localparam logic [31:0] SRC1 = 32'hB1B1_0001;
   localparam logic [31:0] STG0 = 32'h0000_1234;
   localparam logic [31:0] STG1 = 32'h0000_5678;
   localparam logic [31:0] STG2 = 32'h9ABC_DEF0;

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        d_valid;
   logic                        d_we;
   logic [ADDR_W-1:0]           d_dst;
   logic [TNEW_W-1:0]           d_tnew;
   logic [NUM_SRC*ADDR_W-1:0]   d_src_addr;
   logic [NUM_SRC*TNEW_W-1:0]   d_src_tuse;
   logic [NUM_SRC*DATA_W-1:0]   d_src_data;
   logic [DEPTH*DATA_W-1:0]     stage_data;
   logic                        flush;
   logic                        stall;
   logic [NUM_SRC*DATA_W-1:0]   src_fwd_data;
   logic [DEPTH-1:0]            stage_we;
   logic [31:0]                 stall_cnt;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   fwd_scoreboard #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .TNEW_W(TNEW_W)
   ) dut (
      .clk(clk), .reset(reset), .d_valid(d_valid), .d_we(d_we), .d_dst(d_dst),
      .d_tnew(d_tnew), .d_src_addr(d_src_addr), .d_src_tuse(d_src_tuse),
      .d_src_data(d_src_data), .stage_data(stage_data), .flush(flush),
      .stall(stall), .src_fwd_data(src_fwd_data), .stage_we(stage_we), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic push(input string t, input logic [31:0] v);
      tag_q.push_back(t);
      exp_q.push_back(v);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      string       t;
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty observed=%h expected=none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic idle();
      d_valid    = 1'b0;
      d_we       = 1'b0;
      d_dst      = '0;
      d_tnew     = '0;
      d_src_addr = '0;
      d_src_tuse = '0;
      flush      = 1'b0;
   endtask

   task automatic produce(input logic [ADDR_W-1:0] dst, input logic [TNEW_W-1:0] tnew);
      idle();
      d_valid = 1'b1;
      d_we    = 1'b1;
      d_dst   = dst;
      d_tnew  = tnew;
   endtask

   task automatic consume(input int unsigned k, input logic [ADDR_W-1:0] addr,
                          input logic [TNEW_W-1:0] tuse);
      d_src_addr[k*ADDR_W +: ADDR_W] = addr;
      d_src_tuse[k*TNEW_W +: TNEW_W] = tuse;
   endtask

   task automatic drain();
      idle();
      repeat (4) @(negedge clk);
   endtask

   initial begin
      reset      = 1'b1;
      idle();
      d_src_data = {SRC1, SRC0};
      stage_data = {STG2, STG1, STG0};

      // Reset state
      #1;
      push("rst_stall", 32'd0);        pop_check(32'(stall));
      push("rst_stage_we", 32'd0);     pop_check(32'(stage_we));
      push("rst_cnt", 32'd0);          pop_check(stall_cnt);
      push("rst_fwd0", SRC0);          pop_check(src_fwd_data[31:0]);
      push("rst_fwd1", SRC1);          pop_check(src_fwd_data[63:32]);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // ALU producer r5, tnew=0
      produce(5'd5, 2'd0);
      @(negedge clk);
      idle();
      consume(0, 5'd5, 2'd1);
      push("alu_fwd_e", STG0);         push("alu_stall_e", 32'd0);   push("alu_we_e", 32'd1);
      #1;
      pop_check(src_fwd_data[31:0]);   pop_check(32'(stall));        pop_check(32'(stage_we));
      @(negedge clk);
      push("alu_fwd_m", STG1);         push("alu_stall_m", 32'd0);   push("alu_we_m", 32'd2);
      #1;
      pop_check(src_fwd_data[31:0]);   pop_check(32'(stall));        pop_check(32'(stage_we));
      drain();

      // Load-use on r8
      produce(5'd8, 2'd1);
      @(negedge clk);
      idle();
      d_valid = 1'b1;
      consume(1, 5'd8, 2'd0);
      push("lu_stall", 32'd1);         push("lu_we0", 32'd1);
      #1;
      pop_check(32'(stall));           pop_check(32'(stage_we));
      @(negedge clk);
      push("lu_stall_after", 32'd0);   push("lu_fwd1", STG1);
      push("lu_cnt", 32'd1);           push("lu_bubble_we", 32'd2);
      #1;
      pop_check(32'(stall));           pop_check(src_fwd_data[63:32]);
      pop_check(stall_cnt);            pop_check(32'(stage_we));
      drain();

      // Two producers to r3, both ready: youngest wins
      produce(5'd3, 2'd0);
      @(negedge clk); idle();
      @(negedge clk); produce(5'd3, 2'd0);
      @(negedge clk); idle();
      consume(0, 5'd3, 2'd0);
      push("two_fwd0", STG0);          push("two_stall", 32'd0);     push("two_we", 32'd5);
      #1;
      pop_check(src_fwd_data[31:0]);   pop_check(32'(stall));        pop_check(32'(stage_we));
      drain();

      // Two producers to r3, youngest unready: older ready one must not mask it
      produce(5'd3, 2'd0);
      @(negedge clk); idle();
      @(negedge clk); produce(5'd3, 2'd1);
      @(negedge clk); idle();
      consume(0, 5'd3, 2'd0);
      push("mask_stall", 32'd1);
      #1;
      pop_check(32'(stall));
      @(negedge clk);
      idle();
      push("mask_cnt", 32'd2);         push("mask_stall_after", 32'd0);
      #1;
      pop_check(stall_cnt);            pop_check(32'(stall));
      drain();

      // Register 0 is never tracked
      produce(5'd0, 2'd0);
      @(negedge clk);
      idle();
      consume(0, 5'd0, 2'd0);
      push("r0_we", 32'd0);            push("r0_fwd0", SRC0);        push("r0_stall", 32'd0);
      #1;
      pop_check(32'(stage_we));        pop_check(src_fwd_data[31:0]); pop_check(32'(stall));
      drain();

      // Flushed producer inserts no tag
      produce(5'd7, 2'd0);
      flush = 1'b1;
      @(negedge clk);
      idle();
      push("fl_we", 32'd0);
      #1;
      pop_check(32'(stage_we));
      consume(0, 5'd7, 2'd0);
      push("fl_fwd0", SRC0);           push("fl_stall", 32'd0);      push("fl_cnt", 32'd2);
      #1;
      pop_check(src_fwd_data[31:0]);   pop_check(32'(stall));        pop_check(stall_cnt);
      drain();

      // Reset asserted in the middle of a stall
      produce(5'd9, 2'd2);
      @(negedge clk);
      idle();
      consume(0, 5'd9, 2'd0);
      push("rs_stall_pre", 32'd1);
      #1;
      pop_check(32'(stall));
      reset = 1'b1;
      push("rs_stall", 32'd0);         push("rs_we", 32'd0);
      push("rs_cnt", 32'd0);           push("rs_fwd0", SRC0);
      #1;
      pop_check(32'(stall));           pop_check(32'(stage_we));
      pop_check(stall_cnt);            pop_check(src_fwd_data[31:0]);
      @(negedge clk);
      reset = 1'b0;
      push("rs_stall_post", 32'd0);    push("rs_fwd0_post", SRC0);
      #1;
      pop_check(32'(stall));           pop_check(src_fwd_data[31:0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the single-operand forwarding mux.
- Owns a registered tag pipeline that mirrors the datapath stages after Decode. Each tag is {we, dst, tnew}.
- For NUM_SRC operands it selects the youngest matching producer, forwards that producer's data when ready, and raises a stall when a producer's data is not ready in time.
- Sits beside the D-stage register file read and feeds the D/E pipeline register and the hazard control.

Parameters:
- DATA_W, 32, width of data.
- ADDR_W, 5, register address width. Address 0 is hardwired zero.
- NUM_SRC, 2, number of source operands in D.
- DEPTH, 3, tracked stages after D. Index 0 = E, DEPTH-1 = W.
- TNEW_W, 2, width of tnew/tuse fields.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- d_valid  in  1  instruction in D is real, not a bubble.
- d_we  in  1  D instruction writes a register.
- d_dst  in  ADDR_W  destination register of the D instruction.
- d_tnew  in  TNEW_W  cycles after entering E until the result exists.
- d_src_addr  in  NUM_SRC*ADDR_W  source addresses; operand k occupies bits [k*ADDR_W +: ADDR_W].
- d_src_tuse  in  NUM_SRC*TNEW_W  cycles until operand k is consumed.
- d_src_data  in  NUM_SRC*DATA_W  register file read data.
- stage_data  in  DEPTH*DATA_W  result currently held in stage i.
- flush  in  1  kill the D instruction; no tag is inserted.
- stall  out  1  freeze PC/F/D, insert a bubble into E.
- src_fwd_data  out  NUM_SRC*DATA_W  resolved operand values.
- stage_we  out  DEPTH  tag valid/write flags, for debug.
- stall_cnt  out  32  count of stalled cycles, saturating.

Behaviour:
Reset and clocking:
- Asynchronous reset clears every tag to {0,0,0} and clears stall_cnt to 0.
- While reset is asserted: stall=0 and src_fwd_data=d_src_data.
- Tags update on the rising edge of clk.

Tag insertion at index 0:
- Load {1, d_dst, d_tnew} only when d_valid & d_we & (d_dst!=0) & !stall & !flush.
- Otherwise load a bubble {0,0,0}.
- A stall or flush therefore always inserts a bubble.

Tag advance to index i>0:
- Entry i receives entry i-1 with tnew decremented, saturating at 0.
- Downstream entries advance every cycle, regardless of stall or flush.
- The tag leaving index DEPTH-1 is dropped. The register file write occurs that cycle.

Match rule (combinational, per operand k):
- A match is entry i with we=1, dst==addr_k and addr_k!=0.
- Scan from i=0 upward; the lowest index wins, i.e. the youngest producer.
- No match, or addr_k==0, gives src_fwd_data_k = d_src_data_k. For addr 0 this is the regfile value, which is 0.
- Match with tnew==0 gives stage_data[i].
- Match with tnew>0: data is not ready. Output d_src_data_k (don't-care to the consumer); the stall rule decides.

Stall rule:
- stall = OR over k of (match_k & tnew_match_k > tuse_k).
- An older ready producer never masks a younger unready one.
- stall is combinational. It must not depend on stall_cnt.

stall_cnt:
- Increments on each clock edge where stall=1.
- Holds at 32'hFFFF_FFFF.

Simultaneous events:
- flush & stall in the same cycle: a bubble is inserted and stall_cnt still increments.
- Reset mid-stall: stall drops immediately, asynchronously with tag clearing.

Latency:
- Forwarding and stall are zero-cycle (combinational).
- A producer becomes visible at index 0 one cycle after it leaves D.

Test Plan:
- Reset with all inputs at 0 -> stall=0, stage_we=0, stall_cnt=0, src_fwd_data equals d_src_data.
- ALU producer: d_dst=5, d_tnew=0 (ALU result available in E); next cycle src0=5, tuse=1, stage_data[0]=32'h1234 -> src_fwd_data0=32'h1234, stall=0. The following cycle it forwards from index 1 using stage_data[1].
- Load-use: d_dst=8, d_tnew=1; next cycle src1=8, tuse=0 -> stall=1 for exactly 1 cycle with a bubble inserted. Then the tag is at index 1 with tnew=0, forward stage_data[1], and stall_cnt=1.
- Two producers to register 3 at indices 0 (tnew=0, data A) and 2 (data B) -> output A. Same setup with index 0 tnew=1 and tuse=0 -> stall=1 even though B is ready.
- Register 0: producer d_dst=0, d_we=1 -> no tag inserted (stage_we[0]=0). Operand addr 0 -> d_src_data passes through and stall=0.
- flush with d_valid=1, d_we=1, d_dst=7 -> stage_we[0]=0 next cycle, and a later operand on register 7 reads d_src_data. Assert reset during a stall -> stall=0 immediately and all tags cleared.
